bundle_reader: RTL and testbench
================================

BUNDLE_READER -- requirements
Module: bundle_reader

Interface
REQ-001 SHALL have parameter DIM, default 64, giving the number of bundling counters (sign bits); it is a multiple of 32.
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of the store-count field.
REQ-003 SHALL have parameter LAT, default 3, giving the cycles from the last store strobe to the counters' sign bits being valid.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle job start pulse.
REQ-006 SHALL have port store_num  in  CNT_W  number of store strobes in the job, sampled on start.
REQ-007 SHALL have port even_in  in  1  item count is even, sampled on start.
REQ-008 SHALL have port rand_in  in  1  tie-break bit, sampled on start.
REQ-009 SHALL have port store_any  in  1  OR of all core store bits in this cycle.
REQ-010 SHALL have port sign_bits  in  DIM  sign_bit outputs of the counter array.
REQ-011 SHALL have ports ctr_rst, ctr_even and ctr_rand  out  1 each  counter clear/tie-break controls.
REQ-012 SHALL have port busy  out  1  job in progress.
REQ-013 SHALL have ports dout_data  out  32, dout_valid  out  1, dout_last  out  1, and dout_ready  in  1  result word stream.
REQ-014 SHALL have port err  out  1  sticky protocol error flag.

Function
REQ-015 SHALL implement the FSM states IDLE, CLEAR, ACCUM, DRAIN and SEND.
REQ-016 SHALL, in IDLE, on start: latch store_num, even_in and rand_in, then go to CLEAR.
REQ-017 SHALL, in CLEAR, hold for exactly one cycle with ctr_rst=1, ctr_even=latched even and ctr_rand=latched rand, then go to ACCUM.
REQ-018 SHALL, in ACCUM, increment the store counter on each store_any cycle.
REQ-019 SHALL leave ACCUM for DRAIN in the cycle the counter reaches store_num.
REQ-020 SHALL go from CLEAR directly to DRAIN when store_num==0.
REQ-021 SHALL, in DRAIN, wait LAT cycles counted from the last store strobe, capture sign_bits into a DIM-bit register, then go to SEND.
REQ-022 SHALL, in SEND, emit DIM/32 words, word k = captured bits [32k+31:32k], with word 0 first.
REQ-023 SHALL transfer a word only when dout_valid && dout_ready.
REQ-024 SHALL hold dout_data stable while valid && !ready.
REQ-025 SHALL assert dout_last with the final word.
REQ-026 SHALL return to IDLE on the cycle after the final word transfers.
REQ-027 SHALL permit back-to-back words at 1 word/cycle under dout_ready=1.
REQ-028 SHALL keep busy=1 in every state except IDLE.
REQ-029 SHALL ignore start while busy and set err.
REQ-030 SHALL ignore store_any outside ACCUM and set err.
REQ-031 SHALL count a store_any coinciding with the CLEAR cycle as the first store.
REQ-032 SHALL never wrap the store counter; a store after reaching store_num is treated per REQ-030.
REQ-033 SHALL produce latency start -> first dout_valid = 1 (CLEAR) + stores + LAT + 1 cycles.
REQ-034 SHALL clear err only by reset.

Reset
REQ-035 SHALL, while rst_n=0, force the state to IDLE and clear the counter and capture register.
REQ-036 SHALL, while rst_n=0, drive ctr_rst=0, ctr_even=0, ctr_rand=0, busy=0, dout_valid=0, dout_last=0, dout_data=0 and err=0.
REQ-037 SHALL, on reset mid-job, abandon the job and not resume it after release.
REQ-038 SHALL accept start on the first clock edge after rst_n deasserts.

Structure
REQ-039 SHALL place the state enum, the word width (32) and the LAT default in the shared package.
REQ-040 SHALL implement word emission (capture register, word index, valid/last/stall holding) in one sub-module, sign_word_serializer.

Verification
REQ-041 SHALL cover: store_num=3, even=1, rand=1, DIM=64, ready=1 -> ctr_rst pulse with ctr_even=1 and ctr_rand=1; two words, second with last; first valid 8 cycles after start.
REQ-042 SHALL cover: store_num=0 -> no ACCUM; words equal sign_bits sampled LAT cycles after CLEAR.
REQ-043 SHALL cover: ready toggling 1,0,0,1 during SEND -> data held stable while stalled; exactly DIM/32 transfers; busy drops after last.
REQ-044 SHALL cover: start pulsed during ACCUM, plus store_any in IDLE -> job unaffected; err=1 until reset.
REQ-045 SHALL cover: rst_n low in DRAIN -> all outputs 0 asynchronously; a new job after release completes normally.
REQ-046 SHALL cover: sign_bits=64'hA5A5_0000_FFFF_0001 -> words 32'hFFFF_0001 then 32'hA5A5_0000.

Source files
------------

// File: rtl/bundle_reader_pkg.sv
// bundle_reader_pkg
// Shared definitions for the bundle reader slice: the controller state
// encoding, the width of one result word, and the default number of cycles
// the counter array needs before its sign bits settle after the last store.
package bundle_reader_pkg;

  localparam int WORD_W      = 32;
  localparam int LAT_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    SEND  = 3'd4
  } state_e;

endpackage

// File: rtl/bundle_reader_serializer.sv
// sign_word_serializer
// Holds a snapshot of the counter sign bits and streams it out as
// DIM/WORD_W words, lowest word first, over a valid/ready handshake.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   capture_i    load bits_i and start streaming from word 0
//   bits_i       sign bits to snapshot
//   ready_i      consumer accepts the current word
//   data_o       current word (zero when no word is offered)
//   valid_o      a word is offered
//   last_o       the offered word is the final one
//   done_o       the final word transfers this cycle
module sign_word_serializer
  import bundle_reader_pkg::*;
#(
  parameter int DIM = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_i,
  input  logic [DIM-1:0]    bits_i,
  input  logic              ready_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              done_o
);

  localparam int NW = DIM / WORD_W;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  logic [DIM-1:0] cap_q;
  logic [IW-1:0]  idx_q;
  logic           valid_q;
  logic           xfer;
  logic           atLast;

  assign xfer   = valid_q && ready_i;
  assign atLast = (idx_q == IW'(NW - 1));

  // The index only advances on an accepted word, so data stays put while
  // the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (capture_i) begin
      cap_q   <= bits_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (xfer) begin
      if (atLast) begin
        valid_q <= 1'b0;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  assign data_o  = valid_q ? cap_q[int'(idx_q) * WORD_W +: WORD_W] : '0;
  assign valid_o = valid_q;
  assign last_o  = valid_q && atLast;
  assign done_o  = xfer && atLast;

endmodule

// File: rtl/bundle_reader.sv
// bundle_reader
// Sequences one bundling job on an external counter array: clears the
// counters, counts the store strobes of the job, waits for the sign bits to
// settle, snapshots them and streams them out as 32-bit words.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle job start pulse
//   store_num, even_in,        job parameters, sampled on start
//   rand_in
//   store_any                  some core stored this cycle
//   sign_bits                  sign bits of the counter array
//   ctr_rst/ctr_even/ctr_rand  counter clear and tie-break controls
//   busy                       a job is in progress
//   dout_*                     result word stream
//   err                        sticky protocol error
module bundle_reader
  import bundle_reader_pkg::*;
#(
  parameter int DIM   = 64,
  parameter int CNT_W = 32,
  parameter int LAT   = LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  store_num,
  input  logic              even_in,
  input  logic              rand_in,
  input  logic              store_any,
  input  logic [DIM-1:0]    sign_bits,
  output logic              ctr_rst,
  output logic              ctr_even,
  output logic              ctr_rand,
  output logic              busy,
  output logic [WORD_W-1:0] dout_data,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_ready,
  output logic              err
);

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, num_q, num_d, cntInc;
  logic [DW-1:0]    drain_q, drain_d;
  logic             even_q, even_d, rand_q, rand_d, err_q, err_d;
  logic             capture, sendDone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      drain_q <= '0;
      even_q  <= 1'b0;
      rand_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      drain_q <= drain_d;
      even_q  <= even_d;
      rand_q  <= rand_d;
      err_q   <= err_d;
    end
  end

  assign cntInc = cnt_q + CNT_W'(1);

  // A store counts only in ACCUM, or in CLEAR as the first store of a
  // non-empty job; everywhere else it is a protocol error. The counter never
  // wraps because ACCUM is left on the very store that reaches store_num.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    drain_d  = drain_q;
    even_d   = even_q;
    rand_d   = rand_q;
    err_d    = err_q;
    capture  = 1'b0;
    ctr_rst  = 1'b0;
    ctr_even = 1'b0;
    ctr_rand = 1'b0;
    if (start && state_q != IDLE) err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (store_any) err_d = 1'b1;
        if (start) begin
          num_d   = store_num;
          even_d  = even_in;
          rand_d  = rand_in;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        ctr_rst  = 1'b1;
        ctr_even = even_q;
        ctr_rand = rand_q;
        drain_d  = '0;
        if (num_q == '0) begin
          if (store_any) err_d = 1'b1;
          state_d = DRAIN;
        end else if (store_any) begin
          cnt_d   = cntInc;
          state_d = (cntInc == num_q) ? DRAIN : ACCUM;
        end else begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        drain_d = '0;
        if (store_any) begin
          cnt_d = cntInc;
          if (cntInc == num_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (store_any) err_d = 1'b1;
        // The LAT-th cycle after the last store is the first with settled
        // sign bits; the snapshot is taken at the end of it.
        if (drain_q == DW'(LAT - 1)) begin
          capture = 1'b1;
          state_d = SEND;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      SEND: begin
        if (store_any) err_d = 1'b1;
        if (sendDone) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign err  = err_q;

  sign_word_serializer #(
    .DIM(DIM)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (capture),
    .bits_i    (sign_bits),
    .ready_i   (dout_ready),
    .data_o    (dout_data),
    .valid_o   (dout_valid),
    .last_o    (dout_last),
    .done_o    (sendDone)
  );

endmodule

// File: tb/tb_bundle_reader.sv
module tb_bundle_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] store_num;
  logic        even_in;
  logic        rand_in;
  logic        store_any;
  logic [63:0] sign_bits;
  logic        ctr_rst, ctr_even, ctr_rand, busy;
  logic [31:0] dout_data;
  logic        dout_valid, dout_last, dout_ready;
  logic        err;

  int checks = 0;
  int failures = 0;

  bundle_reader #(.DIM(64), .CNT_W(32), .LAT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .store_num  (store_num),
    .even_in    (even_in),
    .rand_in    (rand_in),
    .store_any  (store_any),
    .sign_bits  (sign_bits),
    .ctr_rst    (ctr_rst),
    .ctr_even   (ctr_even),
    .ctr_rand   (ctr_rand),
    .busy       (busy),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_ready (dout_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] num;
    logic        ev;
    logic        rn;
    logic [63:0] sb;
    logic [31:0] w0;
    logic [31:0] w1;
    int          firstCyc;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; start goes high for the following rising edge.
  task automatic applyStimulus(input vec_t v, input bit pokeStart, input string tag);
    int cyc;
    int left;
    store_num = v.num;
    even_in   = v.ev;
    rand_in   = v.rn;
    sign_bits = v.sb;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    checkOutput({tag, ".ctr_rst"}, 64'(ctr_rst), 64'd1);
    checkOutput({tag, ".ctr_even"}, 64'(ctr_even), 64'(v.ev));
    checkOutput({tag, ".ctr_rand"}, 64'(ctr_rand), 64'(v.rn));
    checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
    left = int'(v.num);
    while (!dout_valid && cyc < 60) begin
      if (cyc == 2) checkOutput({tag, ".ctr_rst_off"}, 64'(ctr_rst), 64'd0);
      if (left > 0 && cyc >= v.firstCyc) begin
        store_any = 1'b1;
        left--;
      end else begin
        store_any = 1'b0;
      end
      start = pokeStart && (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    store_any = 1'b0;
    start     = 1'b0;
    checkOutput({tag, ".latency"}, 64'(cyc), 64'(v.lat));
    checkOutput({tag, ".word0"}, 64'(dout_data), 64'(v.w0));
    checkOutput({tag, ".last0"}, 64'(dout_last), 64'd0);
    @(negedge clk);
    checkOutput({tag, ".valid1"}, 64'(dout_valid), 64'd1);
    checkOutput({tag, ".word1"}, 64'(dout_data), 64'(v.w1));
    checkOutput({tag, ".last1"}, 64'(dout_last), 64'd1);
    @(negedge clk);
    checkOutput({tag, ".valid_end"}, 64'(dout_valid), 64'd0);
    checkOutput({tag, ".busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t v;
    int cyc;
    int idx;
    int xfers;
    logic [31:0] expW[2];
    logic readyPat[4];

    vecs[0] = '{32'd3, 1'b1, 1'b1, 64'hA5A5_0000_FFFF_0001, 32'hFFFF_0001, 32'hA5A5_0000, 2, 8};
    vecs[1] = '{32'd0, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 32'h9ABC_DEF0, 32'h1234_5678, 2, 5};
    vecs[2] = '{32'd5, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 32'h0000_0001, 32'hDEAD_BEEF, 2, 10};
    vecs[3] = '{32'd1, 1'b1, 1'b0, 64'h8000_0000_7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 2, 6};
    vecs[4] = '{32'd2, 1'b0, 1'b0, 64'h0F0F_0F0F_F0F0_F0F0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1, 6};

    rst_n      = 1'b0;
    start      = 1'b0;
    store_num  = '0;
    even_in    = 1'b0;
    rand_in    = 1'b0;
    store_any  = 1'b0;
    sign_bits  = '0;
    dout_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.valid", 64'(dout_valid), 64'd0);
    checkOutput("reset.data", 64'(dout_data), 64'd0);
    checkOutput("reset.err", 64'(err), 64'd0);
    checkOutput("reset.ctr", 64'({ctr_rst, ctr_even, ctr_rand}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of complete jobs with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d.err", i), 64'(err), 64'd0);
      @(negedge clk);
    end

    // Empty job with sign bits changing every cycle: the snapshot must be
    // the value present LAT cycles after CLEAR.
    store_num = 32'd0;
    even_in   = 1'b0;
    rand_in   = 1'b0;
    start     = 1'b1;
    sign_bits = {32'd100, 32'd0};
    cyc = 0;
    while (!dout_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      sign_bits = {32'(cyc + 100), 32'(cyc)};
    end
    checkOutput("zero.latency", 64'(cyc), 64'd5);
    checkOutput("zero.word0", 64'(dout_data), 64'd4);
    @(negedge clk);
    checkOutput("zero.word1", 64'(dout_data), 64'd104);
    @(negedge clk);
    checkOutput("zero.busy_end", 64'(busy), 64'd0);

    // Stalled consumer: ready pattern 1,0,0,1 once words are offered.
    readyPat = '{1'b1, 1'b0, 1'b0, 1'b1};
    expW     = '{32'h0000_BEEF, 32'h0000_CAFE};
    store_num = 32'd2;
    sign_bits = 64'h0000_CAFE_0000_BEEF;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!dout_valid && cyc < 40) begin
      store_any = (cyc == 2 || cyc == 3);
      @(negedge clk);
      cyc++;
    end
    store_any = 1'b0;
    checkOutput("stall.latency", 64'(cyc), 64'd7);
    idx   = 0;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("stall.valid%0d", i), 64'(dout_valid), 64'd1);
      checkOutput($sformatf("stall.data%0d", i), 64'(dout_data), 64'(expW[idx]));
      checkOutput($sformatf("stall.last%0d", i), 64'(dout_last), 64'(idx == 1));
      dout_ready = readyPat[i];
      if (readyPat[i]) begin
        idx++;
        xfers++;
      end
      @(negedge clk);
    end
    dout_ready = 1'b1;
    checkOutput("stall.xfers", 64'(xfers), 64'd2);
    checkOutput("stall.valid_end", 64'(dout_valid), 64'd0);
    checkOutput("stall.busy_end", 64'(busy), 64'd0);
    @(negedge clk);

    // Start pulsed during ACCUM: job unaffected, err set and sticky.
    applyStimulus(vecs[0], 1'b1, "poke");
    checkOutput("poke.err", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("poke.err_sticky", 64'(err), 64'd1);

    // Reset clears err; a stray store in IDLE sets it again.
    rst_n = 1'b0;
    #1;
    checkOutput("rst1.err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    store_any = 1'b1;
    @(negedge clk);
    store_any = 1'b0;
    checkOutput("idle_store.err", 64'(err), 64'd1);
    checkOutput("idle_store.busy", 64'(busy), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted in DRAIN: outputs drop at once, job is abandoned.
    store_num = 32'd1;
    start     = 1'b1;
    sign_bits = 64'h1111_2222_3333_4444;
    @(negedge clk);
    start     = 1'b0;
    store_any = 1'b1;
    @(negedge clk);
    store_any = 1'b0;
    @(negedge clk);
    checkOutput("drain.busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("drain_rst.busy", 64'(busy), 64'd0);
    checkOutput("drain_rst.outs", 64'({ctr_rst, ctr_even, ctr_rand, dout_valid, dout_last, err}), 64'd0);
    checkOutput("drain_rst.data", 64'(dout_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abandon.busy%0d", i), 64'(busy), 64'd0);
      checkOutput($sformatf("abandon.valid%0d", i), 64'(dout_valid), 64'd0);
    end

    // Start accepted on the first edge after reset release.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v = vecs[2];
    applyStimulus(v, 1'b0, "after_rst");
    checkOutput("after_rst.err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
